mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy duration, in cycles, of multiply operations.
REQ-002 Parameter DIV_CYCLES, default 10: busy duration, in cycles, of divide operations.
REQ-003 Port clk, input, 1: single clock; all state updates occur on the rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port dataA, input, 32: rs operand from GRF.
REQ-006 Port dataB, input, 32: rt operand from GRF.
REQ-007 Port MDOp, input, 3: operation select; 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU; 6-7 are reserved no-ops.
REQ-008 Port start, input, 1: one-cycle request to launch the MDOp operation.
REQ-009 Port HIWr, input, 1: mthi request; writes dataA to HI.
REQ-010 Port LOWr, input, 1: mtlo request; writes dataA to LO.
REQ-011 Port busy, output, 1: high while an operation is in flight.
REQ-012 Port HI, output, 32: registered HI value.
REQ-013 Port LO, output, 32: registered LO value.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and BUSY.
REQ-015 The IDLE to BUSY transition SHALL occur at an edge where start=1 and MDOp is in 0-5; reserved codes leave the FSM in IDLE.
REQ-016 On that launching edge, dataA, dataB and MDOp SHALL be latched; later operand changes have no effect on the result.
REQ-017 On the launching edge, the counter SHALL load N-1, with N = MULT_CYCLES for ops 0,1,4,5 and N = DIV_CYCLES for ops 2,3.
REQ-018 busy SHALL be high for exactly N cycles, beginning after the launching edge.
REQ-019 At the N-th edge after launch, HI/LO SHALL update, busy SHALL fall, and the FSM SHALL return to IDLE.
REQ-020 Multiply results: MULT gives {HI,LO} = signed 64-bit product; MULTU gives the unsigned 64-bit product.
REQ-021 Accumulate results: MADD/MADDU give {HI,LO} = {HI,LO} + product, taking {HI,LO} at the launching edge, 64-bit wrap-around.
REQ-022 Divide results: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend for DIV.
REQ-023 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-024 Divide by zero (DIV/DIVU with dataB=0) SHALL keep busy for DIV_CYCLES and leave HI/LO unchanged at completion.
REQ-025 In BUSY, start, HIWr and LOWr SHALL be ignored; the upstream stall logic holds the requester.
REQ-026 In IDLE, HIWr/LOWr SHALL write dataA to HI/LO at the next edge; HIWr and LOWr together write both.
REQ-027 In IDLE, if start=1 with a valid op in the same cycle as HIWr/LOWr, start SHALL win and the mthi/mtlo write is discarded.
REQ-028 HI and LO outputs SHALL be registered and SHALL hold their old values throughout BUSY.

Reset
REQ-029 reset=0 SHALL immediately force the FSM to IDLE, counter=0, busy=0, HI=0 and LO=0, including mid-operation.
REQ-030 An in-flight operation aborted by reset SHALL NOT commit any result.

Configuration
REQ-031 When MDU_MADD_EN is defined, MADD and MADDU SHALL be supported as specified in REQ-021.
REQ-032 When MDU_MADD_EN is undefined, MDOp 4 and 5 SHALL be reserved no-ops: no launch, busy stays 0, HI/LO unchanged.

Structure
REQ-033 Package mdu_pkg SHALL hold the MDOp encodings, the IDLE/BUSY state encoding, and the MULT_CYCLES/DIV_CYCLES default constants.
REQ-034 One combinational sub-module, mdu_arith, SHALL compute the 64-bit product/accumulate and the quotient/remainder from the latched operands.
REQ-035 The FSM, counter and HI/LO registers SHALL reside in mdu.

Verification
REQ-036 MULT, dataA=0xFFFFFFFE (-2), dataB=3: busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-037 DIVU, dataA=100, dataB=7: busy high for 10 cycles, then LO=14, HI=2.
REQ-038 DIV, dataA=-7, dataB=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF; separately, DIV by 0 after LO=5 is written: busy for 10 cycles, LO still 5.
REQ-039 HIWr with dataA=0x12345678 in IDLE gives HI=0x12345678; HIWr asserted during BUSY leaves HI unchanged; start and LOWr together in IDLE: LOWr discarded.
REQ-040 Start MULTU, pull reset low at busy cycle 3: busy=0, HI=LO=0 immediately, and no later commit occurs.
REQ-041 With MDU_MADD_EN defined: HI=0, LO=10, then MADD 3 x 4 gives LO=22; with the macro undefined, the same stimulus leaves busy=0 and LO=10.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - MDOp encodings (mdop_e)
//   - FSM state encoding (state_t)
//   - Default busy durations for multiply and divide operations
//   - Helper to classify divide operations
// Optional feature macro: MDU_MADD_EN (see mdu.sv), which enables MADD/MADDU.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } mdop_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  function automatic logic is_div_op(input logic [2:0] op);
    return (mdop_e'(op) == OP_DIV) || (mdop_e'(op) == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational datapath of the multiply/divide unit.
// Computes the result for the latched operation from the latched operands.
// Ports:
//   op        in  [2:0]  latched MDOp
//   a, b      in  [31:0] latched rs / rt operands
//   hi_acc    in  [31:0] HI value used as accumulator base for MADD/MADDU
//   lo_acc    in  [31:0] LO value used as accumulator base for MADD/MADDU
//   res_hi    out [31:0] result destined for HI
//   res_lo    out [31:0] result destined for LO
//   res_valid out        result should be committed (low for divide by zero
//                        and for reserved codes)
// The MADD/MADDU results are always computed here; whether those codes can
// launch at all is decided in mdu.sv under MDU_MADD_EN.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi_acc,
  input  logic [31:0] lo_acc,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        res_valid
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [63:0] acc;
  logic               b_zero;
  logic               sdiv_ovf;
  logic        [31:0] sdiv_b;
  logic        [31:0] udiv_b;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};
  assign acc    = {hi_acc, lo_acc};

  assign b_zero   = (b == 32'd0);
  assign sdiv_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  // Substituting a divisor of 1 covers both hazards: division by zero never
  // reaches the divider, and the one overflowing signed case
  // (0x80000000 / -1) naturally yields quotient 0x80000000, remainder 0.
  assign sdiv_b = (b_zero || sdiv_ovf) ? 32'd1 : b;
  assign udiv_b = b_zero ? 32'd1 : b;

  assign quo_s = $signed(a) / $signed(sdiv_b);
  assign rem_s = $signed(a) % $signed(sdiv_b);
  assign quo_u = a / udiv_b;
  assign rem_u = a % udiv_b;

  always_comb begin
    res_hi    = hi_acc;
    res_lo    = lo_acc;
    res_valid = 1'b0;
    case (mdop_e'(op))
      OP_MULT: begin
        {res_hi, res_lo} = prod_s;
        res_valid        = 1'b1;
      end
      OP_MULTU: begin
        {res_hi, res_lo} = prod_u;
        res_valid        = 1'b1;
      end
      OP_DIV: begin
        res_lo    = quo_s;
        res_hi    = rem_s;
        res_valid = !b_zero;
      end
      OP_DIVU: begin
        res_lo    = quo_u;
        res_hi    = rem_u;
        res_valid = !b_zero;
      end
      OP_MADD: begin
        {res_hi, res_lo} = acc + prod_s;
        res_valid        = 1'b1;
      end
      OP_MADDU: begin
        {res_hi, res_lo} = acc + prod_u;
        res_valid        = 1'b1;
      end
      default: begin
        res_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with HI/LO registers.
// Ports:
//   clk    in         rising-edge clock
//   reset  in         asynchronous active-low reset
//   dataA  in  [31:0] rs operand
//   dataB  in  [31:0] rt operand
//   MDOp   in  [2:0]  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6-7 no-op
//   start  in         launch request for MDOp (honoured only in IDLE)
//   HIWr   in         mthi: HI <= dataA (honoured only in IDLE, start wins)
//   LOWr   in         mtlo: LO <= dataA (honoured only in IDLE, start wins)
//   busy   out        high for exactly N cycles after a launch
//   HI     out [31:0] registered HI
//   LO     out [31:0] registered LO
// Configuration macro: MDU_MADD_EN. When defined, MDOp 4/5 (MADD/MADDU)
// launch; when undefined they are treated as reserved no-ops.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | accepting start / mthi / mtlo
// ST_BUSY | operation in flight, counter counts down to the commit edge
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [2:0]  MDOp,
  input  logic        start,
  input  logic        HIWr,
  input  logic        LOWr,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [31:0]      hi_reg;
  logic [31:0]      lo_reg;

  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             res_valid;
  logic             launch;

  function automatic logic op_launchable(input logic [2:0] op);
    logic ok;
    ok = 1'b0;
    case (mdop_e'(op))
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: ok = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU:                  ok = 1'b1;
`endif
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign launch = start && op_launchable(MDOp);

  // HI/LO cannot change while BUSY, so the live registers equal the values
  // captured at the launching edge and serve directly as the MADD base.
  mdu_arith u_arith (
    .op        (op_q),
    .a         (a_q),
    .b         (b_q),
    .hi_acc    (hi_reg),
    .lo_acc    (lo_reg),
    .res_hi    (res_hi),
    .res_lo    (res_lo),
    .res_valid (res_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      op_q   <= 3'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      hi_reg <= 32'd0;
      lo_reg <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (launch) begin
            state <= ST_BUSY;
            busy  <= 1'b1;
            op_q  <= MDOp;
            a_q   <= dataA;
            b_q   <= dataB;
            cnt   <= is_div_op(MDOp) ? DIV_LOAD : MULT_LOAD;
          end else begin
            if (HIWr) hi_reg <= dataA;
            if (LOWr) lo_reg <= dataA;
          end
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            if (res_valid) begin
              hi_reg <= res_hi;
              lo_reg <= res_lo;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign HI = hi_reg;
  assign LO = lo_reg;

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [2:0]  MDOp;
  logic        start;
  logic        HIWr;
  logic        LOWr;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks   = 0;
  int failures = 0;

  logic [31:0] hi_m;
  logic [31:0] lo_m;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .dataA (dataA),
    .dataB (dataB),
    .MDOp  (MDOp),
    .start (start),
    .HIWr  (HIWr),
    .LOWr  (LOWr),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: plain 64-bit arithmetic on the architectural rules.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] hi, inout logic [31:0] lo,
                                output bit launched, output int n);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    launched = 1'b1;
    n = MC;
    case (op)
      3'd0: begin p = sa * sb; {hi, lo} = p; end
      3'd1: begin p = ua * ub; {hi, lo} = p; end
      3'd2: begin
        n = DC;
        if (b != 0) begin
          q = sa / sb;
          r = sa % sb;
          lo = q[31:0];
          hi = r[31:0];
        end
      end
      3'd3: begin
        n = DC;
        if (b != 0) begin
          lo = 32'(ua / ub);
          hi = 32'(ua % ub);
        end
      end
`ifdef MDU_MADD_EN
      3'd4: begin p = sa * sb; {hi, lo} = {hi, lo} + p; end
      3'd5: begin p = ua * ub; {hi, lo} = {hi, lo} + p; end
`endif
      default: launched = 1'b0;
    endcase
  endfunction

  // Called at a negedge. noise drives HIWr/LOWr alongside start and keeps
  // poking start/HIWr/LOWr throughout the busy window.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit noise);
    bit          launched;
    int          n;
    logic [31:0] hi_old, lo_old;
    hi_old = hi_m;
    lo_old = lo_m;
    model(op, a, b, hi_m, lo_m, launched, n);
    if (!launched && noise) begin
      hi_m = a;
      lo_m = a;
    end
    MDOp  = op;
    dataA = a;
    dataB = b;
    start = 1'b1;
    HIWr  = noise;
    LOWr  = noise;
    @(negedge clk);
    start = 1'b0;
    HIWr  = 1'b0;
    LOWr  = 1'b0;
    dataA = $urandom;
    dataB = $urandom;
    MDOp  = 3'($urandom_range(0, 7));
    if (launched) begin
      for (int i = 0; i < n; i++) begin
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        chk({tag, ".hi_hold"}, HI, hi_old);
        chk({tag, ".lo_hold"}, LO, lo_old);
        if (noise) begin
          start = 1'b1;
          HIWr  = 1'b1;
          LOWr  = 1'b1;
          MDOp  = 3'd0;
          dataA = $urandom;
        end
        @(negedge clk);
      end
      start = 1'b0;
      HIWr  = 1'b0;
      LOWr  = 1'b0;
    end
    chk({tag, ".busy_done"}, 32'(busy), 32'd0);
    chk({tag, ".hi"}, HI, hi_m);
    chk({tag, ".lo"}, LO, lo_m);
  endtask

  task automatic mt(input string tag, input bit h, input bit l, input logic [31:0] d);
    HIWr  = h;
    LOWr  = l;
    dataA = d;
    @(negedge clk);
    HIWr = 1'b0;
    LOWr = 1'b0;
    if (h) hi_m = d;
    if (l) lo_m = d;
    chk({tag, ".hi"}, HI, hi_m);
    chk({tag, ".lo"}, LO, lo_m);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    bit          rn;

    reset = 1'b1;
    dataA = '0;
    dataB = '0;
    MDOp  = '0;
    start = 1'b0;
    HIWr  = 1'b0;
    LOWr  = 1'b0;
    hi_m  = '0;
    lo_m  = '0;
    #1 reset = 1'b0;
    #2;
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.hi", HI, 32'd0);
    chk("reset.lo", LO, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    mt("mthi", 1'b1, 1'b0, 32'h1234_5678);
    mt("mtlo", 1'b0, 1'b1, 32'hCAFE_F00D);
    mt("mthilo", 1'b1, 1'b1, 32'h0BAD_BEEF);

    run_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("mult_neg.hi_const", HI, 32'hFFFF_FFFF);
    chk("mult_neg.lo_const", LO, 32'hFFFF_FFFA);

    run_op("divu", 3'd3, 32'd100, 32'd7, 1'b0);
    chk("divu.lo_const", LO, 32'd14);
    chk("divu.hi_const", HI, 32'd2);

    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_neg.lo_const", LO, 32'hFFFF_FFFD);
    chk("div_neg.hi_const", HI, 32'hFFFF_FFFF);

    mt("mtlo5", 1'b0, 1'b1, 32'd5);
    run_op("div0", 3'd2, 32'd77, 32'd0, 1'b0);
    chk("div0.lo_const", LO, 32'd5);
    run_op("divu0", 3'd3, 32'd77, 32'd0, 1'b0);

    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_ovf.lo_const", LO, 32'h8000_0000);
    chk("div_ovf.hi_const", HI, 32'd0);

    run_op("multu_noise", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op("div_noise", 3'd2, 32'd1000, 32'hFFFF_FFFD, 1'b1);
    run_op("rsv6", 3'd6, 32'd9, 32'd9, 1'b0);
    run_op("rsv7_mt", 3'd7, 32'h5555_AAAA, 32'd9, 1'b1);

    mt("madd_hi0", 1'b1, 1'b0, 32'd0);
    mt("madd_lo10", 1'b0, 1'b1, 32'd10);
    run_op("madd", 3'd4, 32'd3, 32'd4, 1'b0);
`ifdef MDU_MADD_EN
    chk("madd.lo_const", LO, 32'd22);
`else
    chk("madd.lo_const", LO, 32'd10);
`endif
    mt("maddu_base", 1'b1, 1'b1, 32'hFFFF_FFFF);
    run_op("maddu_wrap", 3'd5, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op("madd_neg", 3'd4, 32'hFFFF_FFFF, 32'd7, 1'b0);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) < 2) begin
        mt("rnd_mt", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      end else begin
        rop = 3'($urandom_range(0, 7));
        ra  = $urandom;
        case ($urandom_range(0, 3))
          0:       rb = 32'd0;
          1:       rb = 32'($urandom_range(1, 20));
          2:       rb = -32'($urandom_range(1, 20));
          default: rb = $urandom;
        endcase
        rn = ($urandom_range(0, 3) == 0);
        run_op("rnd_op", rop, ra, rb, rn);
      end
    end

    mt("pre_rst", 1'b1, 1'b1, 32'h7777_1111);
    MDOp  = 3'd1;
    dataA = 32'hFFFF_0000;
    dataB = 32'h0001_FFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_mid.busy_before", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid.busy", 32'(busy), 32'd0);
    chk("rst_mid.hi", HI, 32'd0);
    chk("rst_mid.lo", LO, 32'd0);
    hi_m = '0;
    lo_m = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (MC + 3) @(negedge clk);
    chk("rst_after.busy", 32'(busy), 32'd0);
    chk("rst_after.hi", HI, 32'd0);
    chk("rst_after.lo", LO, 32'd0);

    run_op("post_rst_mult", 3'd0, 32'd12345, 32'hFFFF_FF00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
